shift_seq_ctrl: RTL
===================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The module SHALL have one clock, `clock`, and all state SHALL update on its rising edge.
REQ-002 Reset SHALL be synchronous and active-high on port `clear`.
REQ-003 Port list (name, direction, width, meaning) SHALL be:
- clock, in, 1, system clock
- clear, in, 1, synchronous active-high reset
- start, in, 1, request a new shift operation
- abort, in, 1, cancel the operation in progress
- op, in, 3, operation: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL
- operand, in, 32, value to shift
- shamt, in, 5, shift amount 0-31
- busy, out, 1, operation in progress
- done, out, 1, one-cycle completion pulse
- result, out, 32, shifted value
- remaining, out, 5, steps still to perform

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-005 In IDLE, start=1 SHALL latch op and shamt internally, load result with operand, and load remaining with shamt.
REQ-006 After the REQ-005 load, the next state SHALL be SHIFT when shamt≠0 and DONE when shamt=0.
REQ-007 In SHIFT, each clock SHALL shift result by exactly one bit according to the latched op, and SHALL decrement remaining by 1.
REQ-008 In SHIFT, when remaining=1 at the clock edge, the next state SHALL be DONE and remaining SHALL become 0.
REQ-009 One-bit step definitions for the latched op SHALL be:
- SHR: {0, r[31:1]}
- SHRA: {r[31], r[31:1]}
- SHL: {r[30:0], 0}
- ROR: {r[0], r[31:1]}
- ROL: {r[30:0], r[31]}
REQ-010 Op codes 101-111 SHALL be treated as shamt=0: go directly to DONE with result=operand.
REQ-011 Latency: if start is sampled at edge k, done SHALL be high only in the cycle after edge k+shamt (i.e. shamt+1 cycles after start for shamt≥1, 1 cycle after start for shamt=0).
REQ-012 DONE SHALL last exactly one cycle with done=1 and SHALL then return to IDLE unconditionally.
REQ-013 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-014 start SHALL be ignored whenever busy=1; inputs sampled at the accepted start SHALL NOT be re-sampled during the operation.
REQ-015 result SHALL hold its value in IDLE until the next accepted start.
REQ-016 result SHALL be valid and final whenever done=1.
REQ-017 operand, op and shamt changing after start is accepted SHALL NOT affect the operation.
REQ-018 abort=1 in SHIFT SHALL force the next state to IDLE with no done pulse, and result SHALL keep its partially shifted value.
REQ-019 abort SHALL be ignored in IDLE and DONE.
REQ-020 If abort and start are both 1 in IDLE, start SHALL be accepted normally.
REQ-021 clear SHALL take priority over start and abort.
REQ-022 Outputs SHALL be registered; no combinational path from any input to busy, done or result.

Reset
REQ-023 clear=1 at a clock edge SHALL set state=IDLE, busy=0, done=0, result=0x00000000, remaining=0, and latched op/shamt=0.
REQ-024 clear asserted mid-operation (SHIFT or DONE) SHALL abandon the operation with no done pulse.
REQ-025 The first start after clear is released SHALL be accepted in the same cycle clear is deasserted.

Verification
REQ-026 The bench SHALL cover: SHRA, operand=0x80000000, shamt=4 -> busy for 5 cycles, done in cycle 5 after start, result=0xF8000000.
REQ-027 The bench SHALL cover: SHR, operand=0x80000000, shamt=31 -> done 32 cycles after start, result=0x00000001; remaining counts 31 down to 0.
REQ-028 The bench SHALL cover: ROL, operand=0x80000001, shamt=1 -> result=0x00000003; and ROR, operand=0x00000001, shamt=1 -> result=0x80000000.
REQ-029 The bench SHALL cover: SHL, operand=0x12345678, shamt=0 -> done 1 cycle after start, result=0x12345678; op=111 with shamt=9 -> same response.
REQ-030 The bench SHALL cover: a second start with a different operand pulsed during SHIFT -> ignored, and the first result completes unchanged; abort on the 2nd SHIFT cycle of SHRA 0x80000000 by 8 -> no done, result=0xE0000000, busy=0.
REQ-031 The bench SHALL cover: clear on the 3rd SHIFT cycle -> next cycle busy=0, done=0, result=0x00000000, and no done pulse follows.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle 32-bit shifter: one bit per clock for SHR/SHRA/SHL/ROR/ROL,
// with abort, a one-cycle done pulse and a live step counter.
module shift_seq_ctrl (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        abort,
    input  logic [2:0]  op,
    input  logic [31:0] operand,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  remaining
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [31:0] r_result;
    logic [4:0]  r_remaining;
    logic        r_busy;
    logic        r_done;

    state_t      w_nextState;
    logic [2:0]  w_nextOp;
    logic [31:0] w_nextResult;
    logic [4:0]  w_nextRemaining;
    logic        w_opValid;

    // One-bit step of the latched operation; unused codes never reach SHIFT.
    function automatic logic [31:0] stepOnce(input logic [31:0] value,
                                             input logic [2:0]  opSel);
        logic [31:0] stepped;
        case (opSel)
            OP_SHR:  stepped = {1'b0, value[31:1]};
            OP_SHRA: stepped = {value[31], value[31:1]};
            OP_SHL:  stepped = {value[30:0], 1'b0};
            OP_ROR:  stepped = {value[0], value[31:1]};
            OP_ROL:  stepped = {value[30:0], value[31]};
            default: stepped = value;
        endcase
        return stepped;
    endfunction

    assign w_opValid = (op <= OP_ROL);

    always_comb begin
        w_nextState     = r_state;
        w_nextOp        = r_op;
        w_nextResult    = r_result;
        w_nextRemaining = r_remaining;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextOp     = op;
                    w_nextResult = operand;
                    // Unused op codes behave exactly like a zero-length shift.
                    if (w_opValid && (shamt != 5'd0)) begin
                        w_nextRemaining = shamt;
                        w_nextState     = SHIFT;
                    end else begin
                        w_nextRemaining = 5'd0;
                        w_nextState     = DONE;
                    end
                end
            end

            SHIFT: begin
                // The abort edge still performs its step, leaving the partial value.
                w_nextResult    = stepOnce(r_result, r_op);
                w_nextRemaining = r_remaining - 5'd1;
                if (abort) begin
                    w_nextState = IDLE;
                end else if (r_remaining <= 5'd1) begin
                    w_nextRemaining = 5'd0;
                    w_nextState     = DONE;
                end
            end

            DONE: begin
                w_nextState = IDLE;
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= IDLE;
            r_op        <= 3'd0;
            r_result    <= 32'd0;
            r_remaining <= 5'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_op        <= w_nextOp;
            r_result    <= w_nextResult;
            r_remaining <= w_nextRemaining;
            r_busy      <= (w_nextState != IDLE);
            r_done      <= (w_nextState == DONE);
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign remaining = r_remaining;

endmodule
